// File: rtl/rename_pkg.sv
// Shared rename-stage constants and types: physical register sizing and free list geometry.
package rename_pkg;
    localparam int PHY_REG_NUM        = 64;
    localparam int PHY_REG_ADDR_WIDTH = 6;
    localparam int REG_ADDR_WIDTH     = 5;
    localparam int FREE_BASE          = 32;
    localparam int FL_DEPTH           = PHY_REG_NUM - FREE_BASE;
    localparam int FL_PTR_W           = $clog2(FL_DEPTH);
    localparam int FL_CNT_W           = $clog2(FL_DEPTH + 1);

    typedef logic [PHY_REG_ADDR_WIDTH-1:0] preg_t;
    typedef logic [FL_PTR_W-1:0]           fl_ptr_t;
    typedef logic [FL_CNT_W-1:0]           fl_cnt_t;

    localparam preg_t PREG_ZERO = '0;

    // Indices FREE_BASE..PHY_REG_NUM-1 start out free.
    localparam logic [PHY_REG_NUM-1:0] IN_LIST_RESET =
        {{(PHY_REG_NUM - FREE_BASE){1'b1}}, {FREE_BASE{1'b0}}};
endpackage

// File: rtl/free_list_if.sv
// Rename/commit-side bundle of the physical register free list.
// free_list_err_o exists only when FREE_LIST_CHECK_EN is defined.
interface free_list_if;
    import rename_pkg::*;

    logic    alloc_req_first;
    logic    alloc_req_second;
    preg_t   free_list_rdata_first;
    preg_t   free_list_rdata_second;
    logic    alloc_grant;
    logic    free_ok_one;
    logic    free_ok_two;
    logic    release_first_i;
    preg_t   release_lprd_first_i;
    logic    release_second_i;
    preg_t   release_lprd_second_i;
    fl_cnt_t free_count_o;
`ifdef FREE_LIST_CHECK_EN
    logic    free_list_err_o;
`endif

    modport slave (
        input  alloc_req_first, alloc_req_second,
        input  release_first_i, release_lprd_first_i,
        input  release_second_i, release_lprd_second_i,
        output free_list_rdata_first, free_list_rdata_second,
        output alloc_grant, free_ok_one, free_ok_two, free_count_o
`ifdef FREE_LIST_CHECK_EN
        , output free_list_err_o
`endif
    );

    modport master (
        output alloc_req_first, alloc_req_second,
        output release_first_i, release_lprd_first_i,
        output release_second_i, release_lprd_second_i,
        input  free_list_rdata_first, free_list_rdata_second,
        input  alloc_grant, free_ok_one, free_ok_two, free_count_o
`ifdef FREE_LIST_CHECK_EN
        , input free_list_err_o
`endif
    );
endinterface

// File: rtl/free_list_ptr.sv
// Next-state computation for the free list head, tail and occupancy count.
module free_list_ptr
    import rename_pkg::*;
(
    input  fl_ptr_t    head,
    input  fl_ptr_t    tail,
    input  fl_cnt_t    count,
    input  logic [1:0] nalloc,
    input  logic [1:0] nrelease,
    input  logic       grant,
    output fl_ptr_t    head_next,
    output fl_ptr_t    tail_next,
    output fl_cnt_t    count_next
);
    // Pointers wrap naturally because FL_DEPTH is a power of two.
    assign head_next  = grant ? head + fl_ptr_t'(nalloc) : head;
    assign tail_next  = tail + fl_ptr_t'(nrelease);
    assign count_next = count - (grant ? fl_cnt_t'(nalloc) : fl_cnt_t'(0)) + fl_cnt_t'(nrelease);
endmodule

// File: rtl/free_list.sv
// Circular free list of physical registers: two pops and two reclaims per cycle.
// Define FREE_LIST_CHECK_EN to add the in-list bitmap and sticky free_list_err_o.
module free_list
    import rename_pkg::*;
(
    input  logic clk,
    input  logic rst,
    free_list_if.slave fl
);
    preg_t      mem_reg [FL_DEPTH];
    fl_ptr_t    head_reg, tail_reg, head_next, tail_next;
    fl_cnt_t    count_reg, count_next;
    fl_ptr_t    head_p1, wr1_ptr;
    fl_cnt_t    room;
    logic [1:0] nalloc, nrelease;
    logic       grant, rel0_ok, rel1_ok, acc0, acc1;

    assign head_p1 = head_reg + fl_ptr_t'(1);
    assign fl.free_list_rdata_first  = mem_reg[head_reg];
    assign fl.free_list_rdata_second = fl.alloc_req_first ? mem_reg[head_p1] : mem_reg[head_reg];

    assign nalloc = {1'b0, fl.alloc_req_first} + {1'b0, fl.alloc_req_second};
    assign grant  = fl_cnt_t'(nalloc) <= count_reg;

    // Releases beyond the free capacity are dropped slot by slot.
    assign room     = fl_cnt_t'(FL_DEPTH) - count_reg;
    assign rel0_ok  = fl.release_first_i  && (fl.release_lprd_first_i  != PREG_ZERO);
    assign rel1_ok  = fl.release_second_i && (fl.release_lprd_second_i != PREG_ZERO);
    assign acc0     = rel0_ok && (room != '0);
    assign acc1     = rel1_ok && (room > fl_cnt_t'(acc0));
    assign nrelease = {1'b0, acc0} + {1'b0, acc1};
    assign wr1_ptr  = tail_reg + fl_ptr_t'(acc0);

    assign fl.alloc_grant  = grant;
    assign fl.free_ok_one  = count_reg != '0;
    assign fl.free_ok_two  = count_reg >= fl_cnt_t'(2);
    assign fl.free_count_o = count_reg;

    free_list_ptr u_ptr (
        .head       (head_reg),
        .tail       (tail_reg),
        .count      (count_reg),
        .nalloc     (nalloc),
        .nrelease   (nrelease),
        .grant      (grant),
        .head_next  (head_next),
        .tail_next  (tail_next),
        .count_next (count_next)
    );

    generate
        for (genvar gi = 0; gi < FL_DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    mem_reg[gi] <= preg_t'(FREE_BASE + gi);
                end else if (acc1 && (wr1_ptr == fl_ptr_t'(gi))) begin
                    mem_reg[gi] <= fl.release_lprd_second_i;
                end else if (acc0 && (tail_reg == fl_ptr_t'(gi))) begin
                    mem_reg[gi] <= fl.release_lprd_first_i;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= fl_cnt_t'(FL_DEPTH);
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

`ifdef FREE_LIST_CHECK_EN
    logic [PHY_REG_NUM-1:0] in_list_reg, in_list_next;
    logic                   err_reg, err_hit;

    // Pops clear first, then accepted releases set, so pop-then-reclaim of one index nets to "in list".
    always_comb begin
        in_list_next = in_list_reg;
        err_hit      = 1'b0;
        if (grant && fl.alloc_req_first) begin
            if (!in_list_reg[fl.free_list_rdata_first]) err_hit = 1'b1;
            in_list_next[fl.free_list_rdata_first] = 1'b0;
        end
        if (grant && fl.alloc_req_second) begin
            if (!in_list_reg[fl.free_list_rdata_second]) err_hit = 1'b1;
            in_list_next[fl.free_list_rdata_second] = 1'b0;
        end
        if (rel0_ok) begin
            if (!acc0 || in_list_reg[fl.release_lprd_first_i]) err_hit = 1'b1;
            if (acc0) in_list_next[fl.release_lprd_first_i] = 1'b1;
        end
        if (rel1_ok) begin
            if (!acc1 || in_list_reg[fl.release_lprd_second_i]) err_hit = 1'b1;
            if (acc1) in_list_next[fl.release_lprd_second_i] = 1'b1;
        end
        if (rel0_ok && rel1_ok && (fl.release_lprd_first_i == fl.release_lprd_second_i)) err_hit = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_list_reg <= IN_LIST_RESET;
            err_reg     <= 1'b0;
        end else begin
            in_list_reg <= in_list_next;
            err_reg     <= err_reg | err_hit;
        end
    end

    assign fl.free_list_err_o = err_reg;
`endif
endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list; covers the FREE_LIST_CHECK_EN error flag when that macro is defined.
module tb_free_list;
    import rename_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    free_list_if fl ();

    free_list dut (
        .clk (clk),
        .rst (rst),
        .fl  (fl)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        fl.alloc_req_first       = 1'b0;
        fl.alloc_req_second      = 1'b0;
        fl.release_first_i       = 1'b0;
        fl.release_lprd_first_i  = '0;
        fl.release_second_i      = 1'b0;
        fl.release_lprd_second_i = '0;
    endtask

    initial begin
        idle_inputs();
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Reset state
        chk("rst_count", 32'(fl.free_count_o), 32);
        chk("rst_ok_one", 32'(fl.free_ok_one), 1);
        chk("rst_ok_two", 32'(fl.free_ok_two), 1);
        chk("rst_grant", 32'(fl.alloc_grant), 1);
        chk("rst_rdata_first", 32'(fl.free_list_rdata_first), 32);
`ifdef FREE_LIST_CHECK_EN
        chk("rst_err", 32'(fl.free_list_err_o), 0);
`endif

        // Dual allocation
        fl.alloc_req_first  = 1'b1;
        fl.alloc_req_second = 1'b1;
        #1;
        chk("dual_rdata_first", 32'(fl.free_list_rdata_first), 32);
        chk("dual_rdata_second", 32'(fl.free_list_rdata_second), 33);
        chk("dual_grant", 32'(fl.alloc_grant), 1);
        tick();
        idle_inputs();
        #1;
        chk("dual_count", 32'(fl.free_count_o), 30);
        chk("dual_next_first", 32'(fl.free_list_rdata_first), 34);

        // Asynchronous reset mid-operation
        rst = 1'b0;
        #1;
        chk("async_rst_count", 32'(fl.free_count_o), 32);
        chk("async_rst_first", 32'(fl.free_list_rdata_first), 32);
        tick();
        rst = 1'b1;
        tick();

        // Lone second request takes the head entry
        fl.alloc_req_second = 1'b1;
        #1;
        chk("lone2_rdata_second", 32'(fl.free_list_rdata_second), 32);
        chk("lone2_grant", 32'(fl.alloc_grant), 1);
        tick();
        idle_inputs();
        #1;
        chk("lone2_count", 32'(fl.free_count_o), 31);
        chk("lone2_next_first", 32'(fl.free_list_rdata_first), 33);

        // Drain to one entry
        for (int i = 0; i < 15; i++) begin
            fl.alloc_req_first  = 1'b1;
            fl.alloc_req_second = 1'b1;
            tick();
        end
        #1;
        chk("drain_count", 32'(fl.free_count_o), 1);
        chk("drain_ok_two", 32'(fl.free_ok_two), 0);
        chk("drain_ok_one", 32'(fl.free_ok_one), 1);
        chk("drain_grant_two", 32'(fl.alloc_grant), 0);
        tick();
        fl.alloc_req_second = 1'b0;
        #1;
        chk("nogrant_count", 32'(fl.free_count_o), 1);
        chk("last_rdata_first", 32'(fl.free_list_rdata_first), 63);
        chk("single_grant", 32'(fl.alloc_grant), 1);
        tick();
        idle_inputs();
        #1;
        chk("empty_count", 32'(fl.free_count_o), 0);
        chk("empty_ok_one", 32'(fl.free_ok_one), 0);
        chk("empty_ok_two", 32'(fl.free_ok_two), 0);

        // Empty: release 40/41 with both allocs requested, no bypass
        fl.alloc_req_first       = 1'b1;
        fl.alloc_req_second      = 1'b1;
        fl.release_first_i       = 1'b1;
        fl.release_lprd_first_i  = 6'd40;
        fl.release_second_i      = 1'b1;
        fl.release_lprd_second_i = 6'd41;
        #1;
        chk("nobypass_grant", 32'(fl.alloc_grant), 0);
        tick();
        fl.release_first_i  = 1'b0;
        fl.release_second_i = 1'b0;
        #1;
        chk("reclaim_count", 32'(fl.free_count_o), 2);
        chk("reclaim_rdata_first", 32'(fl.free_list_rdata_first), 40);
        chk("reclaim_rdata_second", 32'(fl.free_list_rdata_second), 41);
        chk("reclaim_grant", 32'(fl.alloc_grant), 1);
        tick();
        idle_inputs();
        #1;
        chk("repop_count", 32'(fl.free_count_o), 0);

        // Zero lprd on slot 0 dropped, slot 1 lands at tail
        fl.release_first_i       = 1'b1;
        fl.release_lprd_first_i  = 6'd0;
        fl.release_second_i      = 1'b1;
        fl.release_lprd_second_i = 6'd45;
        tick();
        idle_inputs();
        #1;
        chk("zero_drop_count", 32'(fl.free_count_o), 1);
        chk("zero_drop_rdata", 32'(fl.free_list_rdata_first), 45);

        // Release while full is ignored
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        fl.release_first_i       = 1'b1;
        fl.release_lprd_first_i  = 6'd50;
        fl.release_second_i      = 1'b1;
        fl.release_lprd_second_i = 6'd50;
        tick();
        idle_inputs();
        #1;
        chk("full_rel_count", 32'(fl.free_count_o), 32);
        chk("full_rel_rdata", 32'(fl.free_list_rdata_first), 32);
`ifdef FREE_LIST_CHECK_EN
        chk("err_set", 32'(fl.free_list_err_o), 1);
        tick();
        chk("err_sticky", 32'(fl.free_list_err_o), 1);
        rst = 1'b0;
        #1;
        chk("err_cleared", 32'(fl.free_list_err_o), 0);
        rst = 1'b1;
`endif

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
